// File: rtl/router_addr_gen.sv
// router_addr_gen
// Per-row address generator. A matching capture strobe latches one output
// coordinate, then the KxK kernel window is walked and one input-feature-map
// address per cycle is pushed into a small first-word-fall-through FIFO.
module router_addr_gen #(
  parameter int ROW_COUNT  = 4,
  parameter int ROW_ID     = 0,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_reg_clear,
  input  logic                  i_en,
  input  logic [ROW_COUNT-1:0]  i_row_id,
  input  logic [ADDR_WIDTH-1:0] i_o_x,
  input  logic [ADDR_WIDTH-1:0] i_o_y,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH-1:0] i_i_size,
  input  logic [ADDR_WIDTH-1:0] i_k_size,
  input  logic                  i_pop,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // Widths wide enough that (x+kx)*size + start + (y+ky) never overflows.
  localparam int PROD_W = 2 * ADDR_WIDTH + 1;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic [ROW_COUNT-1:0] MY_ROW   = ROW_COUNT'(ROW_ID);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] x_reg, x_next;
  logic [ADDR_WIDTH-1:0] y_reg, y_next;
  logic [ADDR_WIDTH-1:0] start_reg, start_next;
  logic [ADDR_WIDTH-1:0] size_reg, size_next;
  logic [ADDR_WIDTH-1:0] k_reg, k_next;
  logic [ADDR_WIDTH-1:0] kx_reg, kx_next;
  logic [ADDR_WIDTH-1:0] ky_reg, ky_next;

  logic [ADDR_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;

  logic                  clr;
  logic                  capture;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ADDR_WIDTH-1:0] k_last;
  logic [ADDR_WIDTH:0]   x_sum;
  logic [ADDR_WIDTH:0]   y_sum;
  logic [PROD_W-1:0]     row_offset;
  logic [ADDR_WIDTH-1:0] gen_addr;

  // Soft clear behaves exactly like reset and wins over everything else.
  assign clr = i_rst | i_reg_clear;

  // Full/empty come from the registered count, so a pop in a full cycle
  // cannot open room for a push until the following cycle.
  assign fifo_full  = (count_reg == CNT_FULL);
  assign fifo_empty = (count_reg == '0);

  assign capture = (state_reg == ST_IDLE) && i_en && (i_row_id == MY_ROW);
  assign push    = (state_reg == ST_GEN) && !fifo_full;
  assign pop     = i_pop && !fifo_empty;
  assign k_last  = k_reg - ADDR_WIDTH'(1);

  // Window address evaluated wide, then wrapped modulo 2^ADDR_WIDTH.
  assign x_sum      = {1'b0, x_reg} + {1'b0, kx_reg};
  assign y_sum      = {1'b0, y_reg} + {1'b0, ky_reg};
  assign row_offset = PROD_W'(x_sum) * PROD_W'(size_reg);
  assign gen_addr   = ADDR_WIDTH'(SUM_W'(start_reg) + SUM_W'(row_offset) + SUM_W'(y_sum));

  // Next-state logic for the IDLE/GEN/DONE controller and the kernel walk.
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    start_next = start_reg;
    size_next  = size_reg;
    k_next     = k_reg;
    kx_next    = kx_reg;
    ky_next    = ky_reg;
    case (state_reg)
      ST_IDLE: begin
        if (capture) begin
          x_next     = i_o_x;
          y_next     = i_o_y;
          start_next = i_start_addr;
          size_next  = i_i_size;
          k_next     = i_k_size;
          kx_next    = '0;
          ky_next    = '0;
          // An empty kernel has nothing to push.
          state_next = (i_k_size == '0) ? ST_DONE : ST_GEN;
        end
      end
      ST_GEN: begin
        if (push) begin
          if (ky_reg == k_last) begin
            ky_next = '0;
            if (kx_reg == k_last) begin
              state_next = ST_DONE;
            end else begin
              kx_next = kx_reg + ADDR_WIDTH'(1);
            end
          end else begin
            ky_next = ky_reg + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Controller and latched-operand registers.
  always_ff @(posedge i_clk) begin
    if (clr) begin
      state_reg <= ST_IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      start_reg <= '0;
      size_reg  <= '0;
      k_reg     <= '0;
      kx_reg    <= '0;
      ky_reg    <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      start_reg <= start_next;
      size_reg  <= size_next;
      k_reg     <= k_next;
      kx_reg    <= kx_next;
      ky_reg    <= ky_next;
    end
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // FIFO pointer and count registers.
  always_ff @(posedge i_clk) begin
    if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // FIFO storage; contents need no reset because the count gates visibility.
  always_ff @(posedge i_clk) begin
    if (push && !clr) begin
      fifo_mem[wr_ptr_reg] <= gen_addr;
    end
  end

  // Head falls through; an empty FIFO presents zero.
  assign o_addr  = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
  assign o_empty = fifo_empty;
  assign o_full  = fifo_full;
  assign o_busy  = (state_reg == ST_GEN);
  assign o_done  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_router_addr_gen.sv
// tb_router_addr_gen
// Table-driven vectors plus hand-written multi-cycle sequences; addresses
// are checked through a scoreboard queue filled when a capture is driven.
module tb_router_addr_gen;

  localparam int AW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_reg_clear;
  logic          i_en;
  logic [3:0]    i_row_id;
  logic [AW-1:0] i_o_x;
  logic [AW-1:0] i_o_y;
  logic [AW-1:0] i_start_addr;
  logic [AW-1:0] i_i_size;
  logic [AW-1:0] i_k_size;
  logic          i_pop;
  logic [AW-1:0] o_addr;
  logic          o_empty;
  logic          o_full;
  logic          o_busy;
  logic          o_done;

  router_addr_gen #(
    .ROW_COUNT (4),
    .ROW_ID    (1),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_reg_clear (i_reg_clear),
    .i_en        (i_en),
    .i_row_id    (i_row_id),
    .i_o_x       (i_o_x),
    .i_o_y       (i_o_y),
    .i_start_addr(i_start_addr),
    .i_i_size    (i_i_size),
    .i_k_size    (i_k_size),
    .i_pop       (i_pop),
    .o_addr      (o_addr),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 i_clk = ~i_clk;

  int            vec_cnt  = 0;
  int            miss_cnt = 0;
  int            pops;
  logic [AW-1:0] first_pop;
  logic [AW-1:0] last_pop;
  logic [AW-1:0] sb_q [$];

  // Reference window for x=2, y=4, start=0x10, size=8, K=3.
  logic [AW-1:0] ref_win [9] = '{8'h24, 8'h25, 8'h26, 8'h2C, 8'h2D, 8'h2E, 8'h34, 8'h35, 8'h36};

  typedef struct {
    logic [3:0]    row;
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    logic [AW-1:0] start;
    logic [AW-1:0] size;
    logic [AW-1:0] k;
    int            exp_n;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
    logic          exp_done;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: score a pop that will happen at this edge, then advance.
  task automatic cycle();
    logic [AW-1:0] e;
    if (i_rst || i_reg_clear) begin
      sb_q.delete();
    end else if (i_pop && !o_empty) begin
      if (sb_q.size() == 0) begin
        vec_cnt++;
        miss_cnt++;
        $display("FAIL unexpected_pop: got 0x%02h, expected no data", o_addr);
      end else begin
        e = sb_q.pop_front();
        chk("sb_addr", {24'd0, o_addr}, {24'd0, e});
      end
      if (pops == 0) first_pop = o_addr;
      last_pop = o_addr;
      pops++;
      $display("pop #%0d addr=0x%02h", pops, o_addr);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_push(input logic [AW-1:0] x, input logic [AW-1:0] y,
                            input logic [AW-1:0] start, input logic [AW-1:0] size,
                            input logic [AW-1:0] k);
    int a;
    for (int kx = 0; kx < int'(k); kx++) begin
      for (int ky = 0; ky < int'(k); ky++) begin
        a = int'(start) + (int'(x) + kx) * int'(size) + (int'(y) + ky);
        sb_q.push_back(AW'(a));
      end
    end
  endtask

  // Drive one capture strobe; 'accept' says whether the bench expects it taken.
  task automatic capture(input logic [3:0] row, input logic [AW-1:0] x, input logic [AW-1:0] y,
                         input logic [AW-1:0] start, input logic [AW-1:0] size,
                         input logic [AW-1:0] k, input bit accept);
    i_en = 1'b1;
    i_row_id = row;
    i_o_x = x;
    i_o_y = y;
    i_start_addr = start;
    i_i_size = size;
    i_k_size = k;
    if (accept) model_push(x, y, start, size, k);
    cycle();
    i_en = 1'b0;
  endtask

  task automatic clear_dut();
    i_reg_clear = 1'b1;
    cycle();
    i_reg_clear = 1'b0;
    pops = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{4'd1, 8'd2, 8'd4, 8'h10, 8'd8,  8'd3, 9, 8'h24, 8'h36, 1'b1};
    vt[1] = '{4'd2, 8'd2, 8'd4, 8'h10, 8'd8,  8'd3, 0, 8'h00, 8'h00, 1'b0};
    vt[2] = '{4'd1, 8'd1, 8'd0, 8'hF0, 8'd16, 8'd1, 1, 8'h00, 8'h00, 1'b1};
    vt[3] = '{4'd1, 8'd2, 8'd4, 8'h10, 8'd8,  8'd0, 0, 8'h00, 8'h00, 1'b1};
    vt[4] = '{4'd1, 8'd0, 8'd0, 8'h00, 8'd5,  8'd2, 4, 8'h00, 8'h06, 1'b1};
    vt[5] = '{4'd1, 8'd3, 8'd2, 8'hC0, 8'h20, 8'd2, 4, 8'h22, 8'h43, 1'b1};

    i_rst = 1'b1;
    i_reg_clear = 1'b0;
    i_en = 1'b0;
    i_row_id = '0;
    i_o_x = '0;
    i_o_y = '0;
    i_start_addr = '0;
    i_i_size = '0;
    i_k_size = '0;
    i_pop = 1'b0;
    pops = 0;
    repeat (3) cycle();
    i_rst = 1'b0;

    // Reset state
    chk("rst_empty", {31'd0, o_empty}, 32'd1);
    chk("rst_full",  {31'd0, o_full},  32'd0);
    chk("rst_busy",  {31'd0, o_busy},  32'd0);
    chk("rst_done",  {31'd0, o_done},  32'd0);
    chk("rst_addr",  {24'd0, o_addr},  32'd0);

    // Table: capture, pop every cycle, check totals and end state
    for (int i = 0; i < 6; i++) begin
      clear_dut();
      i_pop = 1'b1;
      capture(vt[i].row, vt[i].x, vt[i].y, vt[i].start, vt[i].size, vt[i].k, vt[i].row == 4'd1);
      repeat (20) cycle();
      i_pop = 1'b0;
      chk("tbl_count", pops, vt[i].exp_n);
      if (vt[i].exp_n > 0) begin
        chk("tbl_first", {24'd0, first_pop}, {24'd0, vt[i].exp_first});
        chk("tbl_last",  {24'd0, last_pop},  {24'd0, vt[i].exp_last});
      end
      chk("tbl_done",  {31'd0, o_done},  {31'd0, vt[i].exp_done});
      chk("tbl_busy",  {31'd0, o_busy},  32'd0);
      chk("tbl_empty", {31'd0, o_empty}, 32'd1);
      chk("tbl_sb_left", sb_q.size(), 0);
    end

    // Latency, exact stream, done timing, strobes ignored in GEN and DONE
    clear_dut();
    i_pop = 1'b0;
    for (int j = 0; j < 9; j++) sb_q.push_back(ref_win[j]);
    capture(4'd1, 8'd2, 8'd4, 8'h10, 8'd8, 8'd3, 1'b0);
    chk("lat_busy_after_capture",  {31'd0, o_busy},  32'd1);
    chk("lat_empty_after_capture", {31'd0, o_empty}, 32'd1);
    i_pop = 1'b1;
    cycle();
    chk("lat_first_push_visible", {31'd0, o_empty}, 32'd0);
    for (int j = 0; j < 40 && pops < 9; j++) begin
      if (pops == 7) begin
        chk("done_before_last", {31'd0, o_done}, 32'd0);
        chk("busy_before_last", {31'd0, o_busy}, 32'd1);
      end
      if (pops == 8) begin
        chk("done_at_last", {31'd0, o_done}, 32'd1);
        chk("busy_at_last", {31'd0, o_busy}, 32'd0);
      end
      if (j == 3) begin
        i_en = 1'b1;
        i_row_id = 4'd1;
        i_o_x = 8'd0;
        i_o_y = 8'd0;
        i_start_addr = 8'h80;
        i_k_size = 8'd1;
      end else begin
        i_en = 1'b0;
      end
      cycle();
    end
    i_en = 1'b0;
    chk("stream_count", pops, 9);
    i_en = 1'b1;
    cycle();
    i_en = 1'b0;
    repeat (3) cycle();
    chk("done_ignores_en_empty", {31'd0, o_empty}, 32'd1);
    chk("done_sticky", {31'd0, o_done}, 32'd1);

    // Full stall, then pop one every two cycles
    clear_dut();
    i_pop = 1'b0;
    capture(4'd1, 8'd2, 8'd4, 8'h10, 8'd8, 8'd3, 1'b1);
    repeat (4) cycle();
    chk("full_after_4", {31'd0, o_full}, 32'd1);
    repeat (3) cycle();
    chk("stall_full", {31'd0, o_full}, 32'd1);
    chk("stall_busy", {31'd0, o_busy}, 32'd1);
    chk("stall_head", {24'd0, o_addr}, 32'h24);
    for (int j = 0; j < 80 && !(o_empty && o_done); j++) begin
      i_pop = (j % 2 == 0);
      cycle();
    end
    i_pop = 1'b0;
    chk("slow_drain_count", pops, 9);
    chk("slow_drain_sb_left", sb_q.size(), 0);
    chk("slow_drain_done", {31'd0, o_done}, 32'd1);

    // Pop while empty, then push+pop with two entries held
    clear_dut();
    i_pop = 1'b1;
    capture(4'd1, 8'd0, 8'd0, 8'h00, 8'd5, 8'd2, 1'b1);
    cycle();
    i_pop = 1'b0;
    cycle();
    i_pop = 1'b1;
    cycle();
    i_pop = 1'b0;
    cycle();
    chk("pp_done", {31'd0, o_done}, 32'd1);
    chk("pp_not_full", {31'd0, o_full}, 32'd0);
    chk("pp_not_empty", {31'd0, o_empty}, 32'd0);
    i_pop = 1'b1;
    for (int j = 0; j < 10 && !o_empty; j++) cycle();
    chk("pp_total_pops", pops, 4);
    repeat (3) cycle();
    i_pop = 1'b0;
    chk("pop_empty_stays", {31'd0, o_empty}, 32'd1);
    chk("pop_empty_full", {31'd0, o_full}, 32'd0);

    // Soft clear in the 5th GEN cycle, restart from the window origin
    clear_dut();
    i_pop = 1'b1;
    capture(4'd1, 8'd2, 8'd4, 8'h10, 8'd8, 8'd3, 1'b1);
    repeat (4) cycle();
    clear_dut();
    chk("clr_empty", {31'd0, o_empty}, 32'd1);
    chk("clr_done",  {31'd0, o_done},  32'd0);
    chk("clr_busy",  {31'd0, o_busy},  32'd0);
    cycle();
    pops = 0;
    for (int j = 0; j < 9; j++) sb_q.push_back(ref_win[j]);
    capture(4'd1, 8'd2, 8'd4, 8'h10, 8'd8, 8'd3, 1'b0);
    for (int j = 0; j < 40 && pops < 9; j++) cycle();
    i_pop = 1'b0;
    chk("restart_count", pops, 9);
    chk("restart_first", {24'd0, first_pop}, 32'h24);
    chk("restart_sb_left", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
